// File: rtl/ars_gf2m_pkg.sv
// Shared constants, types and the multiply-by-x^n reduction helper for the
// GF(2^233) field datapath, f(x) = x^233 + x^74 + 1.
package ars_gf2m_pkg;

    localparam int GF_M = 233;
    localparam int GF_K = 74;

    typedef logic [GF_M-1:0] gf_elem_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // elem * x^n mod f for n <= 16; each single shift folds x^233 back onto x^74 + 1
    function automatic gf_elem_t gf_mulx_red(input gf_elem_t elem, input int n);
        gf_elem_t r;
        logic     msb;
        r = elem;
        for (int i = 0; i < 16; i++) begin
            if (i < n) begin
                msb     = r[GF_M-1];
                r       = {r[GF_M-2:0], 1'b0};
                r[0]    = r[0] ^ msb;
                r[GF_K] = r[GF_K] ^ msb;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ars_gf2m_digit_mac.sv
// One digit step of the MSB-first multiplier:
// nxt = acc*x^DIGIT mod f  xor  sum_i bd[i]*A*x^i mod f.
module ars_gf2m_digit_mac
    import ars_gf2m_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  gf_elem_t         acc,
    input  gf_elem_t         a,
    input  logic [DIGIT-1:0] bd,
    output gf_elem_t         nxt
);

    always_comb begin
        nxt = gf_mulx_red(acc, DIGIT);
        for (int i = 0; i < DIGIT; i++) begin
            if (bd[i]) nxt = nxt ^ gf_mulx_red(a, i);
        end
    end

endmodule

// File: rtl/ars_gf2m_modmul.sv
// Digit-serial GF(2^233) multiplier, DOUT = DIN1*DIN2 mod f, start/done handshake.
// Optional fused add of DIN3 into the result when ARS_MODMUL_FMA_EN is defined.
module ars_gf2m_modmul
    import ars_gf2m_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [GF_M-1:0] DIN1,
    input  logic [GF_M-1:0] DIN2,
`ifdef ARS_MODMUL_FMA_EN
    input  logic [GF_M-1:0] DIN3,
`endif
    output logic            BUSY,
    output logic            DONE,
    output logic [GF_M-1:0] DOUT
);

    localparam int NDIG = (GF_M + DIGIT - 1) / DIGIT;
    localparam int BW   = NDIG * DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    gf_elem_t        a_q, acc, acc_nxt, res;
    logic [BW-1:0]   b_q;
    logic            accept, last;

    assign accept = START && !BUSY;
    assign last   = (cnt == CW'(NDIG - 1));

    ars_gf2m_digit_mac #(.DIGIT(DIGIT)) u_mac (
        .acc (acc),
        .a   (a_q),
        .bd  (b_q[BW-1 -: DIGIT]),
        .nxt (acc_nxt)
    );

`ifdef ARS_MODMUL_FMA_EN
    gf_elem_t c_q;

    always_ff @(posedge CLK) begin
        if (RST)         c_q <= '0;
        else if (accept) c_q <= DIN3;
    end

    // addend folded into the last digit step so latency is unchanged
    assign res = acc_nxt ^ c_q;
`else
    assign res = acc_nxt;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (last)   state_nxt = ST_FIN;
            ST_FIN:  state_nxt = START ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == ST_RUN);
        DONE = (state == ST_FIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            DOUT <= '0;
        end else if (accept) begin
            a_q <= DIN1;
            b_q <= BW'(DIN2);
            acc <= '0;
            cnt <= '0;
        end else if (state == ST_RUN) begin
            acc <= acc_nxt;
            b_q <= b_q << DIGIT;
            cnt <= cnt + CW'(1);
            if (last) DOUT <= res;
        end
    end

endmodule

// File: tb/tb_ars_gf2m_modmul.sv
// Self-checking bench for ars_gf2m_modmul against a bit-serial shift-and-reduce model.
module tb_ars_gf2m_modmul;

    localparam int M   = 233;
    localparam int LAT = 31;
`ifdef ARS_MODMUL_FMA_EN
    localparam bit FMA = 1'b1;
`else
    localparam bit FMA = 1'b0;
`endif

    typedef logic [M-1:0] elem_t;

    logic  CLK = 1'b0;
    logic  RST, START;
    elem_t DIN1, DIN2, DIN3;
    logic  BUSY, DONE;
    elem_t DOUT;

    int    checks = 0;
    int    passed = 0;
    elem_t exp_q[$];

    always #5 CLK = ~CLK;

    ars_gf2m_modmul dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .DIN1  (DIN1),
        .DIN2  (DIN2),
`ifdef ARS_MODMUL_FMA_EN
        .DIN3  (DIN3),
`endif
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DOUT  (DOUT)
    );

    function automatic elem_t mulx(input elem_t e);
        elem_t r;
        r = e << 1;
        if (e[M-1]) begin
            r[0]  = r[0] ^ 1'b1;
            r[74] = r[74] ^ 1'b1;
        end
        return r;
    endfunction

    function automatic elem_t ref_mul(input elem_t a, input elem_t b);
        elem_t r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = mulx(r);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic elem_t rnd();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w[M-1:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one accepted request; afterwards the bench sits in cycle 1 of the run
    task automatic launch(input elem_t a, input elem_t b, input elem_t c);
        DIN1  = a;
        DIN2  = b;
        DIN3  = c;
        START = 1'b1;
        exp_q.push_back(ref_mul(a, b) ^ (FMA ? c : elem_t'(0)));
        tick();
        START = 1'b0;
        DIN1  = rnd();
        DIN2  = rnd();
        DIN3  = rnd();
    endtask

    // Returns cycle index (from 1) at which DONE is seen, -1 on timeout
    task automatic wait_done(output int lat, output int busy_bad);
        lat      = -1;
        busy_bad = 0;
        for (int n = 1; n <= 100; n++) begin
            if (DONE) begin
                lat = n;
                if (BUSY) busy_bad++;
                break;
            end
            if (!BUSY) busy_bad++;
            tick();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; DIN1 = '0; DIN2 = '0; DIN3 = '0;
        tick();
        tick();
        checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else passed++;
        checks++; if (DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", DONE); else passed++;
        checks++; if (DOUT !== '0) $display("FAIL reset_dout: got %h want 0", DOUT); else passed++;
        RST = 1'b0;
        tick();
    endtask

    task automatic test_one();
        int lat, bb;
        elem_t e;
        launch(elem_t'(1), elem_t'(1), '0);
        wait_done(lat, bb);
        e = exp_q.pop_front();
        checks++; if (lat !== LAT) $display("FAIL one_latency: got %0d want %0d", lat, LAT); else passed++;
        checks++; if (bb !== 0) $display("FAIL one_busy_profile: got %0d bad cycles want 0", bb); else passed++;
        checks++; if (DOUT !== elem_t'(1)) $display("FAIL one_dout: got %h want 1", DOUT); else passed++;
        checks++; if (DOUT !== e) $display("FAIL one_model: got %h want %h", DOUT, e); else passed++;
        tick();
        checks++; if (DONE !== 1'b0) $display("FAIL one_done_pulse: got %b want 0", DONE); else passed++;
    endtask

    task automatic test_fold();
        int lat, bb;
        elem_t a, want, e;
        a = '0; a[232] = 1'b1;
        want = '0; want[74] = 1'b1; want[0] = 1'b1;
        launch(a, elem_t'(2), '0);
        wait_done(lat, bb);
        e = exp_q.pop_front();
        checks++; if (DOUT !== want) $display("FAIL fold_dout: got %h want %h", DOUT, want); else passed++;
        checks++; if (DOUT !== e) $display("FAIL fold_model: got %h want %h", DOUT, e); else passed++;
        tick();
    endtask

    task automatic test_random();
        int lat, bb;
        elem_t e;
        for (int k = 0; k <= 500; k++) begin
            if (k == 0) launch('1, '1, '0);
            else        launch(rnd(), rnd(), rnd());
            wait_done(lat, bb);
            e = exp_q.pop_front();
            checks++; if (lat !== LAT) $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, LAT); else passed++;
            checks++; if (DOUT !== e) $display("FAIL rand_dout[%0d]: got %h want %h", k, DOUT, e); else passed++;
            tick();
        end
    endtask

    task automatic test_start_ignored();
        int dones, first;
        elem_t e;
        dones = 0; first = -1;
        launch(rnd(), rnd(), rnd());
        for (int n = 1; n <= 70; n++) begin
            if (DONE) begin
                dones++;
                if (first < 0) begin
                    first = n;
                    e = exp_q.pop_front();
                    checks++; if (DOUT !== e) $display("FAIL ign_dout: got %h want %h", DOUT, e); else passed++;
                end
            end
            if (n == 5 || n == 20) begin
                START = 1'b1; DIN1 = rnd(); DIN2 = rnd(); DIN3 = rnd();
            end else begin
                START = 1'b0;
            end
            tick();
        end
        checks++; if (dones !== 1) $display("FAIL ign_done_count: got %0d want 1", dones); else passed++;
        checks++; if (first !== LAT) $display("FAIL ign_latency: got %0d want %0d", first, LAT); else passed++;
    endtask

    task automatic test_reset_abort();
        int lat, bb;
        elem_t e;
        launch(rnd(), rnd(), rnd());
        e = exp_q.pop_back();
        repeat (11) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++; if (BUSY !== 1'b0) $display("FAIL abort_busy: got %b want 0", BUSY); else passed++;
        checks++; if (DONE !== 1'b0) $display("FAIL abort_done: got %b want 0", DONE); else passed++;
        checks++; if (DOUT !== '0) $display("FAIL abort_dout: got %h want 0", DOUT); else passed++;
        launch(rnd(), rnd(), rnd());
        wait_done(lat, bb);
        e = exp_q.pop_front();
        checks++; if (lat !== LAT) $display("FAIL abort_latency: got %0d want %0d", lat, LAT); else passed++;
        checks++; if (DOUT !== e) $display("FAIL abort_dout_after: got %h want %h", DOUT, e); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bb;
        elem_t e1, e2;
        launch(rnd(), rnd(), rnd());
        wait_done(lat, bb);
        e1 = exp_q.pop_front();
        checks++; if (DOUT !== e1) $display("FAIL b2b_first: got %h want %h", DOUT, e1); else passed++;
        launch(rnd(), rnd(), rnd());
        checks++; if (DONE !== 1'b0) $display("FAIL b2b_single_pulse: got %b want 0", DONE); else passed++;
        checks++; if (BUSY !== 1'b1) $display("FAIL b2b_busy: got %b want 1", BUSY); else passed++;
        checks++; if (DOUT !== e1) $display("FAIL b2b_dout_hold: got %h want %h", DOUT, e1); else passed++;
        wait_done(lat, bb);
        e2 = exp_q.pop_front();
        checks++; if (lat !== LAT) $display("FAIL b2b_spacing: got %0d want %0d", lat, LAT); else passed++;
        checks++; if (DOUT !== e2) $display("FAIL b2b_second: got %h want %h", DOUT, e2); else passed++;
        tick();
    endtask

`ifdef ARS_MODMUL_FMA_EN
    task automatic test_fma();
        int lat, bb;
        elem_t c, e;
        c = '0; c[32] = 1'b1; c[0] = 1'b1;
        launch('0, rnd(), c);
        wait_done(lat, bb);
        e = exp_q.pop_front();
        checks++; if (DOUT !== c) $display("FAIL fma_dout: got %h want %h", DOUT, c); else passed++;
        checks++; if (DOUT !== e) $display("FAIL fma_model: got %h want %h", DOUT, e); else passed++;
        checks++; if (lat !== LAT) $display("FAIL fma_latency: got %0d want %0d", lat, LAT); else passed++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_one();
        test_fold();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
`ifdef ARS_MODMUL_FMA_EN
        test_fma();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
